// File: rtl/memory_access.sv
// Memory-access (M) pipeline stage with a MEM/WB register bank and a
// request/acknowledge data-memory port with a bounded wait.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   validM                   M-stage slot holds a real instruction
//   RegWriteM, MemtoRegM     control bits forwarded toward writeback
//   MemReadM, MemWriteM      load / store request (both set = store)
//   ALUOutM                  ALU result, also the byte address of an access
//   WriteDataM               store data
//   WriteRegM                destination register index
//   stallM                   combinational freeze request for IF/ID/EX/MEM
//   dmem_req, dmem_we        memory request and write enable (registered)
//   dmem_addr, dmem_wdata    memory address and write data (registered)
//   dmem_rdata, dmem_ack     read data and completion strobe from memory
//   RegWriteW, MemtoRegW     MEM/WB control bits
//   ReadDataW, ALUOutW       MEM/WB load data and ALU result
//   WriteRegW                MEM/WB destination register index
//   misalignW, busErrW       one-cycle exception flags
module memory_access #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        validM,
    input  logic        RegWriteM,
    input  logic        MemtoRegM,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    input  logic [4:0]  WriteRegM,
    output logic        stallM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        RegWriteW,
    output logic        MemtoRegW,
    output logic [31:0] ReadDataW,
    output logic [31:0] ALUOutW,
    output logic [4:0]  WriteRegW,
    output logic        misalignW,
    output logic        busErrW
);

    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES) > 5) ? $clog2(TIMEOUT_CYCLES) : 5;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dmem_req_q, dmem_req_d;
    logic               dmem_we_q, dmem_we_d;
    logic [31:0]        dmem_addr_q, dmem_addr_d;
    logic [31:0]        dmem_wdata_q, dmem_wdata_d;
    // M-stage control captured at request time, replayed into MEM/WB on ack
    logic               hold_reg_write_q, hold_reg_write_d;
    logic               hold_mem_to_reg_q, hold_mem_to_reg_d;
    logic [4:0]         hold_write_reg_q, hold_write_reg_d;
    logic               reg_write_w_q, reg_write_w_d;
    logic               mem_to_reg_w_q, mem_to_reg_w_d;
    logic [31:0]        read_data_w_q, read_data_w_d;
    logic [31:0]        alu_out_w_q, alu_out_w_d;
    logic [4:0]         write_reg_w_q, write_reg_w_d;
    logic               misalign_w_q, misalign_w_d;
    logic               bus_err_w_q, bus_err_w_d;
    logic               stall_c;
    logic               access_c;
    logic               aligned_c;

    assign access_c  = validM & (MemReadM | MemWriteM);
    assign aligned_c = (ALUOutM[1:0] == 2'b00);

    // Next-state, MEM/WB load and memory-port control
    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        dmem_req_d        = dmem_req_q;
        dmem_we_d         = dmem_we_q;
        dmem_addr_d       = dmem_addr_q;
        dmem_wdata_d      = dmem_wdata_q;
        hold_reg_write_d  = hold_reg_write_q;
        hold_mem_to_reg_d = hold_mem_to_reg_q;
        hold_write_reg_d  = hold_write_reg_q;
        reg_write_w_d     = reg_write_w_q;
        mem_to_reg_w_d    = mem_to_reg_w_q;
        read_data_w_d     = read_data_w_q;
        alu_out_w_d       = alu_out_w_q;
        write_reg_w_d     = write_reg_w_q;
        misalign_w_d      = 1'b0;
        bus_err_w_d       = 1'b0;
        stall_c           = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (access_c) begin
                    // The access instruction itself never writes back from here
                    reg_write_w_d  = 1'b0;
                    mem_to_reg_w_d = 1'b0;
                    if (aligned_c) begin
                        stall_c           = 1'b1;
                        state_d           = BUSY;
                        cnt_d             = '0;
                        dmem_req_d        = 1'b1;
                        dmem_we_d         = MemWriteM;
                        dmem_addr_d       = ALUOutM;
                        dmem_wdata_d      = WriteDataM;
                        hold_reg_write_d  = RegWriteM;
                        hold_mem_to_reg_d = MemtoRegM;
                        hold_write_reg_d  = WriteRegM;
                    end else begin
                        misalign_w_d = 1'b1;
                    end
                end else begin
                    reg_write_w_d  = validM & RegWriteM;
                    mem_to_reg_w_d = validM & MemtoRegM;
                    alu_out_w_d    = ALUOutM;
                    write_reg_w_d  = WriteRegM;
                end
            end
            BUSY: begin
                if (dmem_ack) begin
                    // Ack wins even on the final allowed cycle
                    if (!dmem_we_q) begin
                        read_data_w_d = dmem_rdata;
                    end
                    reg_write_w_d  = hold_reg_write_q & ~dmem_we_q;
                    mem_to_reg_w_d = hold_mem_to_reg_q;
                    alu_out_w_d    = dmem_addr_q;
                    write_reg_w_d  = hold_write_reg_q;
                    dmem_req_d     = 1'b0;
                    dmem_we_d      = 1'b0;
                    state_d        = IDLE;
                end else begin
                    reg_write_w_d  = 1'b0;
                    mem_to_reg_w_d = 1'b0;
                    if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        dmem_req_d  = 1'b0;
                        dmem_we_d   = 1'b0;
                        bus_err_w_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        stall_c = 1'b1;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and register bank
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= IDLE;
            cnt_q             <= '0;
            dmem_req_q        <= 1'b0;
            dmem_we_q         <= 1'b0;
            dmem_addr_q       <= '0;
            dmem_wdata_q      <= '0;
            hold_reg_write_q  <= 1'b0;
            hold_mem_to_reg_q <= 1'b0;
            hold_write_reg_q  <= '0;
            reg_write_w_q     <= 1'b0;
            mem_to_reg_w_q    <= 1'b0;
            read_data_w_q     <= '0;
            alu_out_w_q       <= '0;
            write_reg_w_q     <= '0;
            misalign_w_q      <= 1'b0;
            bus_err_w_q       <= 1'b0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            dmem_req_q        <= dmem_req_d;
            dmem_we_q         <= dmem_we_d;
            dmem_addr_q       <= dmem_addr_d;
            dmem_wdata_q      <= dmem_wdata_d;
            hold_reg_write_q  <= hold_reg_write_d;
            hold_mem_to_reg_q <= hold_mem_to_reg_d;
            hold_write_reg_q  <= hold_write_reg_d;
            reg_write_w_q     <= reg_write_w_d;
            mem_to_reg_w_q    <= mem_to_reg_w_d;
            read_data_w_q     <= read_data_w_d;
            alu_out_w_q       <= alu_out_w_d;
            write_reg_w_q     <= write_reg_w_d;
            misalign_w_q      <= misalign_w_d;
            bus_err_w_q       <= bus_err_w_d;
        end
    end

    // Stall is suppressed while reset is asserted
    assign stallM     = stall_c & ~rst;
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign RegWriteW  = reg_write_w_q;
    assign MemtoRegW  = mem_to_reg_w_q;
    assign ReadDataW  = read_data_w_q;
    assign ALUOutW    = alu_out_w_q;
    assign WriteRegW  = write_reg_w_q;
    assign misalignW  = misalign_w_q;
    assign busErrW    = bus_err_w_q;

endmodule

// File: tb/tb_memory_access.sv
// Scoreboard bench for memory_access: expected writeback events are queued
// as stimulus is driven and popped when the DUT produces a W-stage event.
module tb_memory_access;

    localparam int unsigned TIMEOUT = 4;

    logic        clk;
    logic        rst;
    logic        validM, RegWriteM, MemtoRegM, MemReadM, MemWriteM;
    logic [31:0] ALUOutM, WriteDataM;
    logic [4:0]  WriteRegM;
    logic        stallM;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ack;
    logic        RegWriteW, MemtoRegW;
    logic [31:0] ReadDataW, ALUOutW;
    logic [4:0]  WriteRegW;
    logic        misalignW, busErrW;

    memory_access #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .validM(validM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WriteRegM(WriteRegM),
        .stallM(stallM),
        .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
        .ReadDataW(ReadDataW), .ALUOutW(ALUOutW), .WriteRegW(WriteRegW),
        .misalignW(misalignW), .busErrW(busErrW)
    );

    typedef struct {
        logic        rw;
        logic        mtr;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wr;
        logic        mis;
        logic        be;
        bit          full;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_rdata = 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h @%0t", tag, got, exp, $time);
        end
    endtask

    // Writeback monitor: any visible W event must match the head of the queue
    always @(negedge clk) begin
        if (!rst && (RegWriteW === 1'b1 || misalignW === 1'b1 || busErrW === 1'b1)) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_w_event", 32'(RegWriteW), 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("w_regwrite", 32'(RegWriteW), 32'(e.rw));
                check_eq("w_readdata", ReadDataW, e.rd);
                check_eq("w_misalign", 32'(misalignW), 32'(e.mis));
                check_eq("w_buserr", 32'(busErrW), 32'(e.be));
                if (e.full) begin
                    check_eq("w_memtoreg", 32'(MemtoRegW), 32'(e.mtr));
                    check_eq("w_aluout", ALUOutW, e.alu);
                    check_eq("w_writereg", 32'(WriteRegW), 32'(e.wr));
                end
            end
        end
    end

    task automatic clear_m();
        validM = 1'b0; RegWriteM = 1'b0; MemtoRegM = 1'b0;
        MemReadM = 1'b0; MemWriteM = 1'b0;
        ALUOutM = '0; WriteDataM = '0; WriteRegM = '0;
    endtask

    // Non-memory instruction: one-cycle latency, never stalls
    task automatic alu_op(input logic [31:0] alu, input logic [4:0] wr);
        exp_t e;
        e = '{rw: 1'b1, mtr: 1'b0, rd: exp_rdata, alu: alu, wr: wr, mis: 1'b0, be: 1'b0, full: 1'b1};
        sb.push_back(e);
        validM = 1'b1; RegWriteM = 1'b1; ALUOutM = alu; WriteRegM = wr;
        @(negedge clk);
        check_eq("alu_stall", 32'(stallM), 32'h0);
        @(posedge clk); #1;
        clear_m();
    endtask

    // Load/store with memory acking ack_delay cycles after the first request
    // cycle (ack_delay < 0 means never ack)
    task automatic mem_op(input bit st, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic rw, input logic [4:0] wr, input int ack_delay,
                          input logic [31:0] rdata);
        exp_t e;
        int   busy, stalls, reqs, exp_stalls, exp_reqs;
        bit   done, mis;
        mis = (addr[1:0] != 2'b00);
        if (mis) begin
            e = '{rw: 1'b0, mtr: 1'b0, rd: exp_rdata, alu: '0, wr: '0, mis: 1'b1, be: 1'b0, full: 1'b0};
            sb.push_back(e);
            exp_stalls = 0; exp_reqs = 0;
        end else if (ack_delay < 0) begin
            e = '{rw: 1'b0, mtr: 1'b0, rd: exp_rdata, alu: '0, wr: '0, mis: 1'b0, be: 1'b1, full: 1'b0};
            sb.push_back(e);
            exp_stalls = TIMEOUT; exp_reqs = TIMEOUT;
        end else begin
            if (!st) begin
                exp_rdata = rdata;
                e = '{rw: rw, mtr: 1'b1, rd: rdata, alu: addr, wr: wr, mis: 1'b0, be: 1'b0, full: 1'b1};
                sb.push_back(e);
            end
            exp_stalls = ack_delay + 1; exp_reqs = ack_delay + 1;
        end
        validM = 1'b1; RegWriteM = rw; MemtoRegM = !st; MemReadM = !st; MemWriteM = st;
        ALUOutM = addr; WriteDataM = wdata; WriteRegM = wr;
        busy = 0; stalls = 0; reqs = 0; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (dmem_req) begin
                dmem_ack = (busy == ack_delay);
                dmem_rdata = rdata;
                busy++;
                reqs++;
            end else begin
                dmem_ack = 1'b0;
            end
            @(negedge clk);
            if (stallM) stalls++;
            if (dmem_req) begin
                check_eq("req_addr", dmem_addr, addr);
                check_eq("req_we", 32'(dmem_we), 32'(st));
                if (st) check_eq("req_wdata", dmem_wdata, wdata);
            end
            @(posedge clk); #1;
            if (!dmem_req) done = 1'b1;
        end
        check_eq("mem_done", 32'(done), 32'h1);
        check_eq("stall_cycles", 32'(stalls), 32'(exp_stalls));
        check_eq("req_cycles", 32'(reqs), 32'(exp_reqs));
        clear_m();
        dmem_ack = 1'b0;
        if (st) begin
            @(negedge clk);
            check_eq("store_regwrite", 32'(RegWriteW), 32'h0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_m();
        dmem_ack = 1'b0;
        dmem_rdata = '0;

        // Reset values, and no stall while reset is held even with an access
        repeat (2) @(posedge clk);
        #1;
        validM = 1'b1; MemReadM = 1'b1; ALUOutM = 32'h100;
        @(negedge clk);
        check_eq("rst_stall", 32'(stallM), 32'h0);
        check_eq("rst_req", 32'(dmem_req), 32'h0);
        check_eq("rst_we", 32'(dmem_we), 32'h0);
        check_eq("rst_addr", dmem_addr, 32'h0);
        check_eq("rst_wdata", dmem_wdata, 32'h0);
        check_eq("rst_regwrite", 32'(RegWriteW), 32'h0);
        check_eq("rst_readdata", ReadDataW, 32'h0);
        check_eq("rst_aluout", ALUOutW, 32'h0);
        check_eq("rst_writereg", 32'(WriteRegW), 32'h0);
        check_eq("rst_flags", 32'({misalignW, busErrW, MemtoRegW}), 32'h0);
        @(posedge clk); #1;
        clear_m();
        rst = 1'b0;

        alu_op(32'h1234, 5'd5);
        mem_op(1'b0, 32'h100, 32'h0, 1'b1, 5'd7, 2, 32'hDEADBEEF);
        mem_op(1'b1, 32'h200, 32'hCAFEF00D, 1'b1, 5'd3, 0, 32'h0);
        mem_op(1'b0, 32'h102, 32'h0, 1'b1, 5'd8, 0, 32'h11111111);
        mem_op(1'b0, 32'h300, 32'h0, 1'b1, 5'd9, -1, 32'h22222222);
        alu_op(32'hABCD, 5'd9);
        mem_op(1'b0, 32'h400, 32'h0, 1'b1, 5'd10, int'(TIMEOUT) - 1, 32'h55AA33CC);

        // Ack while idle is ignored
        dmem_ack = 1'b1; dmem_rdata = 32'h77777777;
        @(negedge clk);
        check_eq("idle_ack_stall", 32'(stallM), 32'h0);
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        @(negedge clk);
        check_eq("idle_ack_req", 32'(dmem_req), 32'h0);
        check_eq("idle_ack_readdata", ReadDataW, exp_rdata);
        @(posedge clk); #1;

        // Reset on the second BUSY cycle abandons the access
        validM = 1'b1; RegWriteM = 1'b1; MemtoRegM = 1'b1; MemReadM = 1'b1;
        ALUOutM = 32'h500; WriteRegM = 5'd4;
        @(posedge clk); #1;
        check_eq("rb_req_rise", 32'(dmem_req), 32'h1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_eq("rb_stall_in_rst", 32'(stallM), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        clear_m();
        exp_rdata = 32'h0;
        dmem_ack = 1'b1; dmem_rdata = 32'h0BAD0BAD;
        @(negedge clk);
        check_eq("rb_req", 32'(dmem_req), 32'h0);
        check_eq("rb_stall", 32'(stallM), 32'h0);
        check_eq("rb_addr", dmem_addr, 32'h0);
        check_eq("rb_regwrite", 32'(RegWriteW), 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("rb_regwrite2", 32'(RegWriteW), 32'h0);
        check_eq("rb_readdata", ReadDataW, 32'h0);
        check_eq("rb_req2", 32'(dmem_req), 32'h0);
        @(posedge clk); #1;
        dmem_ack = 1'b0;

        alu_op(32'h00C0FFEE, 5'd31);
        repeat (3) @(posedge clk);
        #1;
        check_eq("sb_empty", 32'(sb.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
